// File: rtl/rf_pkg.sv
// rf_pkg: constants and types shared by the register-file port arbiter.
//   - DATA_W / ADDR_W / BPOS_W : register data, address and bit-position widths
//   - OP_*    : command opcodes carried on reqN_op
//   - BITOP_* : bit-operation codes forwarded to the register file
//   - state_t : controller FSM states (also visible on dbg_state)
package rf_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int BPOS_W = 4;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_SWAP  = 2'b01;
    localparam logic [1:0] OP_BITOP = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    localparam logic [1:0] BITOP_SET    = 2'b00;
    localparam logic [1:0] BITOP_CLR    = 2'b01;
    localparam logic [1:0] BITOP_TOGGLE = 2'b10;
    localparam logic [1:0] BITOP_RSVD   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/rf_rr_arbiter.sv
// rf_rr_arbiter: two-way round-robin grant for the register-file port.
// Optional feature macro: RF_ARB_LOCK_EN (adds lock hold).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_valid[1:0]  request valids (bit n = requester n)
//   i_open        controller can accept a command this cycle
//   i_lock[1:0]   (RF_ARB_LOCK_EN) lock request of each requester
//   i_in_done     (RF_ARB_LOCK_EN) controller is in its response cycle
//   o_grant_any   some requester is granted this cycle
//   o_grant_id    index of the granted requester
module rf_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_valid,
    input  logic       i_open,
`ifdef RF_ARB_LOCK_EN
    input  logic [1:0] i_lock,
    input  logic       i_in_done,
`endif
    output logic       o_grant_any,
    output logic       o_grant_id
);

    logic r_ptr;
    logic w_accept;
    logic w_both;

    assign w_accept = i_open && o_grant_any;
    assign w_both   = (i_valid == 2'b11);

`ifdef RF_ARB_LOCK_EN
    logic r_lock_active;
    logic r_lock_id;
    logic w_lock_hold;

    // The lock drops combinationally when its owner shows no valid in the
    // response cycle, so the other requester can be served in that same cycle.
    assign w_lock_hold = r_lock_active && !(i_in_done && !i_valid[r_lock_id]);

    always_comb begin
        o_grant_any = |i_valid;
        o_grant_id  = w_both ? r_ptr : i_valid[1];
        if (w_lock_hold) begin
            o_grant_any = i_valid[r_lock_id];
            o_grant_id  = r_lock_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr         <= 1'b0;
            r_lock_active <= 1'b0;
            r_lock_id     <= 1'b0;
        end else if (w_accept) begin
            if (w_both && !w_lock_hold) begin
                r_ptr <= ~o_grant_id;
            end
            r_lock_active <= i_lock[o_grant_id];
            r_lock_id     <= o_grant_id;
        end else if (r_lock_active && !w_lock_hold) begin
            r_lock_active <= 1'b0;
        end
    end
`else
    always_comb begin
        o_grant_any = |i_valid;
        o_grant_id  = w_both ? r_ptr : i_valid[1];
    end

    // Pointer only moves when both contended; a lone requester leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (w_accept && w_both) begin
            r_ptr <= ~o_grant_id;
        end
    end
`endif

endmodule

// File: rtl/rf_port_arbiter.sv
// rf_port_arbiter: shares the 8 x 16-bit register file command port between
// req0 (core pipeline) and req1 (debug/loader). One command per 2 cycles:
// accept (IDLE/DONE) -> ISSUE (rf_* strobes valid) -> DONE (response held).
// Optional feature macro: RF_ARB_LOCK_EN (adds req0_lock / req1_lock).
// Handshake: a command transfers on the rising edge where reqN_valid and
// reqN_ready are both high; ready is combinational from valid and is only
// raised in IDLE or DONE, to the granted requester. Fields are sampled only
// at that edge.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   reqN_valid/ready          command handshake, N = 0,1
//   reqN_op/ra/rb/data        opcode, primary/secondary address, write data
//   reqN_bitop/bitpos         bit-op code and bit position
//   rf_*                      register file command port (ISSUE cycle only)
//   rf_read_data_0/1          register file read data (captured for READ)
//   rsp_valid/id/data0/data1  completion pulse held for the DONE cycle
//   dbg_state                 current FSM state
module rf_port_arbiter
    import rf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [1:0]        req0_op,
    input  logic [ADDR_W-1:0] req0_ra,
    input  logic [ADDR_W-1:0] req0_rb,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [1:0]        req0_bitop,
    input  logic [BPOS_W-1:0] req0_bitpos,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [1:0]        req1_op,
    input  logic [ADDR_W-1:0] req1_ra,
    input  logic [ADDR_W-1:0] req1_rb,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [1:0]        req1_bitop,
    input  logic [BPOS_W-1:0] req1_bitpos,
`ifdef RF_ARB_LOCK_EN
    input  logic              req0_lock,
    input  logic              req1_lock,
`endif
    output logic              rf_write_en,
    output logic              rf_swap_en,
    output logic              rf_bit_op_en,
    output logic [ADDR_W-1:0] rf_read_addr_0,
    output logic [ADDR_W-1:0] rf_read_addr_1,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_data_in,
    output logic [1:0]        rf_bit_op,
    output logic [BPOS_W-1:0] rf_bit_position,
    input  logic [DATA_W-1:0] rf_read_data_0,
    input  logic [DATA_W-1:0] rf_read_data_1,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data0,
    output logic [DATA_W-1:0] rsp_data1,
    output logic [1:0]        dbg_state
);

    state_t            r_state;
    state_t            w_next_state;
    logic              w_open;
    logic              w_grant_any;
    logic              w_grant_id;
    logic              w_accept;

    logic              r_id;
    logic [1:0]        r_op;
    logic [ADDR_W-1:0] r_ra;
    logic [ADDR_W-1:0] r_rb;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_bitop;
    logic [BPOS_W-1:0] r_bitpos;
    logic [DATA_W-1:0] r_rsp_d0;
    logic [DATA_W-1:0] r_rsp_d1;

    assign w_open     = (r_state != ST_ISSUE);
    assign w_accept   = w_open && w_grant_any;
    assign req0_ready = w_accept && !w_grant_id;
    assign req1_ready = w_accept && w_grant_id;
    assign dbg_state  = r_state;

    rf_rr_arbiter u_arb (
        .clk         (clk),
        .rst         (rst),
        .i_valid     ({req1_valid, req0_valid}),
        .i_open      (w_open),
`ifdef RF_ARB_LOCK_EN
        .i_lock      ({req1_lock, req0_lock}),
        .i_in_done   (r_state == ST_DONE),
`endif
        .o_grant_any (w_grant_any),
        .o_grant_id  (w_grant_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_id     <= 1'b0;
            r_op     <= OP_WRITE;
            r_ra     <= '0;
            r_rb     <= '0;
            r_data   <= '0;
            r_bitop  <= '0;
            r_bitpos <= '0;
            r_rsp_d0 <= '0;
            r_rsp_d1 <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_id     <= w_grant_id;
                r_op     <= w_grant_id ? req1_op     : req0_op;
                r_ra     <= w_grant_id ? req1_ra     : req0_ra;
                r_rb     <= w_grant_id ? req1_rb     : req0_rb;
                r_data   <= w_grant_id ? req1_data   : req0_data;
                r_bitop  <= w_grant_id ? req1_bitop  : req0_bitop;
                r_bitpos <= w_grant_id ? req1_bitpos : req0_bitpos;
            end
            // Read data is captured on the same edge the register file commits.
            if (r_state == ST_ISSUE) begin
                r_rsp_d0 <= (r_op == OP_READ) ? rf_read_data_0 : '0;
                r_rsp_d1 <= (r_op == OP_READ) ? rf_read_data_1 : '0;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  w_next_state = w_accept ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: w_next_state = ST_DONE;
            ST_DONE:  w_next_state = w_accept ? ST_ISSUE : ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        rf_write_en     = 1'b0;
        rf_swap_en      = 1'b0;
        rf_bit_op_en    = 1'b0;
        rf_read_addr_0  = '0;
        rf_read_addr_1  = '0;
        rf_write_addr   = '0;
        rf_data_in      = '0;
        rf_bit_op       = '0;
        rf_bit_position = '0;
        if (r_state == ST_ISSUE) begin
            case (r_op)
                OP_WRITE: begin
                    rf_write_en   = 1'b1;
                    rf_write_addr = r_ra;
                    rf_data_in    = r_data;
                end
                OP_SWAP: begin
                    rf_write_en    = 1'b1;
                    rf_swap_en     = 1'b1;
                    rf_write_addr  = r_ra;
                    rf_read_addr_0 = r_ra;
                    rf_read_addr_1 = r_rb;
                end
                OP_BITOP: begin
                    rf_write_en     = 1'b1;
                    rf_bit_op_en    = 1'b1;
                    rf_write_addr   = r_ra;
                    rf_bit_op       = r_bitop;
                    rf_bit_position = r_bitpos;
                end
                default: begin
                    rf_read_addr_0 = r_ra;
                    rf_read_addr_1 = r_rb;
                end
            endcase
        end
    end

    assign rsp_valid = (r_state == ST_DONE);
    assign rsp_id    = rsp_valid && r_id;
    assign rsp_data0 = rsp_valid ? r_rsp_d0 : '0;
    assign rsp_data1 = rsp_valid ? r_rsp_d1 : '0;

endmodule

// File: tb/tb_rf_port_arbiter.sv
module tb_rf_port_arbiter;
    import rf_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic              req0_valid = 0, req1_valid = 0;
    logic              req0_ready, req1_ready;
    logic [1:0]        req0_op = 0, req1_op = 0;
    logic [ADDR_W-1:0] req0_ra = 0, req0_rb = 0, req1_ra = 0, req1_rb = 0;
    logic [DATA_W-1:0] req0_data = 0, req1_data = 0;
    logic [1:0]        req0_bitop = 0, req1_bitop = 0;
    logic [BPOS_W-1:0] req0_bitpos = 0, req1_bitpos = 0;
`ifdef RF_ARB_LOCK_EN
    logic              req0_lock = 0, req1_lock = 0;
`endif
    logic              rf_write_en, rf_swap_en, rf_bit_op_en;
    logic [ADDR_W-1:0] rf_read_addr_0, rf_read_addr_1, rf_write_addr;
    logic [DATA_W-1:0] rf_data_in, rf_read_data_0, rf_read_data_1;
    logic [1:0]        rf_bit_op;
    logic [BPOS_W-1:0] rf_bit_position;
    logic              rsp_valid, rsp_id;
    logic [DATA_W-1:0] rsp_data0, rsp_data1;
    logic [1:0]        dbg_state;

    rf_port_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_ra(req0_ra), .req0_rb(req0_rb), .req0_data(req0_data),
        .req0_bitop(req0_bitop), .req0_bitpos(req0_bitpos),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_ra(req1_ra), .req1_rb(req1_rb), .req1_data(req1_data),
        .req1_bitop(req1_bitop), .req1_bitpos(req1_bitpos),
`ifdef RF_ARB_LOCK_EN
        .req0_lock(req0_lock), .req1_lock(req1_lock),
`endif
        .rf_write_en(rf_write_en), .rf_swap_en(rf_swap_en), .rf_bit_op_en(rf_bit_op_en),
        .rf_read_addr_0(rf_read_addr_0), .rf_read_addr_1(rf_read_addr_1),
        .rf_write_addr(rf_write_addr), .rf_data_in(rf_data_in),
        .rf_bit_op(rf_bit_op), .rf_bit_position(rf_bit_position),
        .rf_read_data_0(rf_read_data_0), .rf_read_data_1(rf_read_data_1),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data0(rsp_data0), .rsp_data1(rsp_data1),
        .dbg_state(dbg_state)
    );

    function automatic logic [15:0] f_bitop(logic [15:0] v, logic [1:0] op, logic [3:0] pos);
        logic [15:0] r;
        r = v;
        case (op)
            BITOP_SET:    r[pos] = 1'b1;
            BITOP_CLR:    r[pos] = 1'b0;
            BITOP_TOGGLE: r[pos] = ~r[pos];
            default:      ;
        endcase
        return r;
    endfunction

    // ---------------- register file environment ----------------
    logic [15:0] rf_mem [8];
    initial for (int i = 0; i < 8; i++) rf_mem[i] = '0;
    assign rf_read_data_0 = rf_mem[rf_read_addr_0];
    assign rf_read_data_1 = rf_mem[rf_read_addr_1];
    always @(posedge clk) begin
        if (rf_write_en) begin
            if (rf_swap_en) begin
                rf_mem[rf_read_addr_0] <= rf_mem[rf_read_addr_1];
                rf_mem[rf_read_addr_1] <= rf_mem[rf_read_addr_0];
            end else if (rf_bit_op_en) begin
                rf_mem[rf_write_addr] <= f_bitop(rf_mem[rf_write_addr], rf_bit_op, rf_bit_position);
            end else begin
                rf_mem[rf_write_addr] <= rf_data_in;
            end
        end
    end

    // ---------------- scoreboard counters ----------------
    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- behavioural model ----------------
    // Transaction view: a command accepted at an edge occupies the next cycle
    // as its issue cycle and the one after as its response cycle.
    bit          m_init = 0;
    bit          m_issue = 0, m_done = 0;
    logic        m_ptr = 0;
    logic        m_c_id;
    logic [1:0]  m_c_op, m_c_bitop;
    logic [2:0]  m_c_ra, m_c_rb;
    logic [15:0] m_c_data;
    logic [3:0]  m_c_bitpos;
    logic        m_rsp_id;
    logic [15:0] m_rsp_d0, m_rsp_d1;
    logic [15:0] m_regs [8];
    bit          m_lock_act = 0;
    logic        m_lock_id = 0;
    initial for (int i = 0; i < 8; i++) m_regs[i] = '0;

    // returns {hold, any, grant_id}
    function automatic logic [2:0] f_grant();
        logic v0, v1, any, g, hold;
        v0 = req0_valid; v1 = req1_valid;
        any = v0 | v1;
        g = (v0 && v1) ? m_ptr : v1;
        hold = 1'b0;
`ifdef RF_ARB_LOCK_EN
        if (m_lock_act && !(m_done && !(m_lock_id ? v1 : v0))) begin
            hold = 1'b1;
            g = m_lock_id;
            any = m_lock_id ? v1 : v0;
        end
`endif
        return {hold, any, g};
    endfunction

    always @(posedge clk) begin : model
        logic [2:0] gr;
        bit acc, both;
        logic [15:0] t;
        gr   = f_grant();
        both = req0_valid && req1_valid;
        acc  = !m_issue && gr[1];
        // The register file commits whatever was issued, reset or not.
        if (m_issue) begin
            case (m_c_op)
                OP_WRITE: m_regs[m_c_ra] = m_c_data;
                OP_SWAP: begin
                    t = m_regs[m_c_ra];
                    m_regs[m_c_ra] = m_regs[m_c_rb];
                    m_regs[m_c_rb] = t;
                end
                OP_BITOP: m_regs[m_c_ra] = f_bitop(m_regs[m_c_ra], m_c_bitop, m_c_bitpos);
                default: ;
            endcase
        end
        if (rst) begin
            m_init = 1; m_issue = 0; m_done = 0; m_ptr = 0; m_lock_act = 0;
        end else begin
            m_done = m_issue;
            if (m_issue) begin
                m_rsp_id = m_c_id;
                m_rsp_d0 = (m_c_op == OP_READ) ? m_regs[m_c_ra] : 16'h0;
                m_rsp_d1 = (m_c_op == OP_READ) ? m_regs[m_c_rb] : 16'h0;
            end
            if (acc) begin
                m_c_id     = gr[0];
                m_c_op     = gr[0] ? req1_op : req0_op;
                m_c_ra     = gr[0] ? req1_ra : req0_ra;
                m_c_rb     = gr[0] ? req1_rb : req0_rb;
                m_c_data   = gr[0] ? req1_data : req0_data;
                m_c_bitop  = gr[0] ? req1_bitop : req0_bitop;
                m_c_bitpos = gr[0] ? req1_bitpos : req0_bitpos;
                if (both && !gr[2]) m_ptr = !gr[0];
`ifdef RF_ARB_LOCK_EN
                m_lock_act = gr[0] ? req1_lock : req0_lock;
                m_lock_id  = gr[0];
            end else if (m_lock_act && !gr[2]) begin
                m_lock_act = 0;
`endif
            end
            m_issue = acc;
        end
    end

    // ---------------- compare process + monitor ----------------
    int   n_we = 0, n_swap = 0, n_bop = 0, n_rsp = 0;
    int   last_rsp_cyc = 0, first_we_cyc = 0;
    logic last_id;
    logic [15:0] last_d0, last_d1;
    logic rsp_ids[$];

    always @(negedge clk) begin
        logic [2:0] gr;
        logic e_we, e_sw, e_bo;
        logic [2:0] e_r0, e_r1, e_wa;
        logic [15:0] e_din;
        logic [1:0] e_bop, e_st;
        logic [3:0] e_bpos;
        if (m_init) begin
            gr = f_grant();
            e_we = 0; e_sw = 0; e_bo = 0; e_r0 = 0; e_r1 = 0; e_wa = 0;
            e_din = 0; e_bop = 0; e_bpos = 0;
            if (m_issue) begin
                e_we = (m_c_op != OP_READ);
                e_sw = (m_c_op == OP_SWAP);
                e_bo = (m_c_op == OP_BITOP);
                e_wa = (m_c_op != OP_READ) ? m_c_ra : 3'd0;
                e_r0 = (m_c_op == OP_SWAP || m_c_op == OP_READ) ? m_c_ra : 3'd0;
                e_r1 = (m_c_op == OP_SWAP || m_c_op == OP_READ) ? m_c_rb : 3'd0;
                e_din = (m_c_op == OP_WRITE) ? m_c_data : 16'h0;
                e_bop = (m_c_op == OP_BITOP) ? m_c_bitop : 2'd0;
                e_bpos = (m_c_op == OP_BITOP) ? m_c_bitpos : 4'd0;
            end
            e_st = m_issue ? ST_ISSUE : (m_done ? ST_DONE : ST_IDLE);
            chk("req0_ready", 32'(req0_ready), 32'(!m_issue && gr[1] && !gr[0]));
            chk("req1_ready", 32'(req1_ready), 32'(!m_issue && gr[1] && gr[0]));
            chk("rf_write_en", 32'(rf_write_en), 32'(e_we));
            chk("rf_swap_en", 32'(rf_swap_en), 32'(e_sw));
            chk("rf_bit_op_en", 32'(rf_bit_op_en), 32'(e_bo));
            chk("rf_write_addr", 32'(rf_write_addr), 32'(e_wa));
            chk("rf_read_addr_0", 32'(rf_read_addr_0), 32'(e_r0));
            chk("rf_read_addr_1", 32'(rf_read_addr_1), 32'(e_r1));
            chk("rf_data_in", 32'(rf_data_in), 32'(e_din));
            chk("rf_bit_op", 32'(rf_bit_op), 32'(e_bop));
            chk("rf_bit_position", 32'(rf_bit_position), 32'(e_bpos));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_done));
            chk("rsp_id", 32'(rsp_id), 32'(m_done && m_rsp_id));
            chk("rsp_data0", 32'(rsp_data0), m_done ? 32'(m_rsp_d0) : 32'h0);
            chk("rsp_data1", 32'(rsp_data1), m_done ? 32'(m_rsp_d1) : 32'h0);
            chk("dbg_state", 32'(dbg_state), 32'(e_st));
        end
        if (rf_write_en === 1'b1) begin
            if (n_we == 0) first_we_cyc = cyc;
            n_we++;
        end
        if (rf_swap_en === 1'b1) n_swap++;
        if (rf_bit_op_en === 1'b1) n_bop++;
        if (rsp_valid === 1'b1) begin
            n_rsp++;
            last_rsp_cyc = cyc;
            last_id = rsp_id;
            last_d0 = rsp_data0;
            last_d1 = rsp_data1;
            rsp_ids.push_back(rsp_id);
        end
    end

    // ---------------- driver tasks ----------------
    int acc_cyc = 0;

    task automatic set_req(input int who, input logic v, input logic [1:0] op,
                           input logic [2:0] ra, input logic [2:0] rb,
                           input logic [15:0] data, input logic [1:0] bop,
                           input logic [3:0] bpos);
        if (who == 0) begin
            req0_valid = v; req0_op = op; req0_ra = ra; req0_rb = rb;
            req0_data = data; req0_bitop = bop; req0_bitpos = bpos;
        end else begin
            req1_valid = v; req1_op = op; req1_ra = ra; req1_rb = rb;
            req1_data = data; req1_bitop = bop; req1_bitpos = bpos;
        end
    endtask

    // Call just after a rising edge; returns just after the handshake edge.
    task automatic send(input int who, input logic [1:0] op, input logic [2:0] ra,
                        input logic [2:0] rb, input logic [15:0] data,
                        input logic [1:0] bop, input logic [3:0] bpos);
        logic hs;
        hs = 0;
        set_req(who, 1'b1, op, ra, rb, data, bop, bpos);
        for (int i = 0; i < 20 && !hs; i++) begin
            @(negedge clk);
            hs = (who == 0) ? req0_ready : req1_ready;
            @(posedge clk);
        end
        #1;
        acc_cyc = cyc;
        chk("handshake", 32'(hs), 32'h1);
        if (who == 0) req0_valid = 0; else req1_valid = 0;
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    int w0, s0, r0;
    initial begin
        @(posedge clk); #1;
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        @(posedge clk); #1;

        // WRITE 1234h @2 from req0: one write strobe, response one cycle after issue
        send(0, OP_WRITE, 3'd2, 3'd0, 16'h1234, 2'd0, 4'd0);
        settle();
        chk("write_pulses", 32'(n_we), 32'd1);
        chk("write_issue_cycle", 32'(first_we_cyc - acc_cyc), 32'd0);
        chk("write_rsp_latency", 32'(last_rsp_cyc - acc_cyc), 32'd1);
        chk("write_rsp_id", 32'(last_id), 32'h0);

        send(0, OP_WRITE, 3'd5, 3'd0, 16'h5678, 2'd0, 4'd0);
        settle();

        // READ 2,5 from req1
        w0 = n_we;
        send(1, OP_READ, 3'd2, 3'd5, 16'h0, 2'd0, 4'd0);
        settle();
        chk("read_d0", 32'(last_d0), 32'h1234);
        chk("read_d1", 32'(last_d1), 32'h5678);
        chk("read_id", 32'(last_id), 32'h1);
        chk("read_no_write", 32'(n_we - w0), 32'd0);

        // contention: both valid for 11 edges -> 6 grants alternating from req0
        rsp_ids.delete();
        set_req(0, 1'b1, OP_WRITE, 3'd1, 3'd0, 16'hAAAA, 2'd0, 4'd0);
        set_req(1, 1'b1, OP_WRITE, 3'd6, 3'd0, 16'hBBBB, 2'd0, 4'd0);
        repeat (11) @(posedge clk);
        #1 req0_valid = 0; req1_valid = 0;
        settle();
        chk("rr_count", 32'(rsp_ids.size()), 32'd6);
        for (int i = 0; i < 6 && i < rsp_ids.size(); i++)
            chk("rr_order", 32'(rsp_ids[i]), 32'(i % 2));

        // SWAP 2,5 then READ 2,5
        s0 = n_swap;
        send(0, OP_SWAP, 3'd2, 3'd5, 16'h0, 2'd0, 4'd0);
        settle();
        chk("swap_pulses", 32'(n_swap - s0), 32'd1);
        send(0, OP_READ, 3'd2, 3'd5, 16'h0, 2'd0, 4'd0);
        settle();
        chk("swap_d0", 32'(last_d0), 32'h5678);
        chk("swap_d1", 32'(last_d1), 32'h1234);

        // BITOP set bit 15 of reg0 (cleared first)
        send(0, OP_WRITE, 3'd0, 3'd0, 16'h0000, 2'd0, 4'd0);
        settle();
        send(0, OP_BITOP, 3'd0, 3'd0, 16'h0, BITOP_SET, 4'hF);
        settle();
        send(0, OP_READ, 3'd0, 3'd1, 16'h0, 2'd0, 4'd0);
        settle();
        chk("bitop_d0", 32'(last_d0), 32'h8000);
        chk("bitop_d1", 32'(last_d1), 32'hAAAA);

        // reset during ISSUE: pointer returns to req0
        set_req(0, 1'b1, OP_WRITE, 3'd3, 3'd0, 16'h3333, 2'd0, 4'd0);
        set_req(1, 1'b1, OP_READ, 3'd2, 3'd5, 16'h0, 2'd0, 4'd0);
        @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        rsp_ids.delete();
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_write_en", 32'(rf_write_en), 32'h0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        @(posedge clk);
        #1 req0_valid = 0; req1_valid = 0;
        settle();
        chk("rst_grant_count", 32'(rsp_ids.size()), 32'd1);
        if (rsp_ids.size() > 0) chk("rst_grant_id", 32'(rsp_ids[0]), 32'h0);

        // SWAP with ra==rb leaves the register unchanged
        send(0, OP_SWAP, 3'd3, 3'd3, 16'h0, 2'd0, 4'd0);
        settle();
        send(1, OP_READ, 3'd3, 3'd3, 16'h0, 2'd0, 4'd0);
        settle();
        chk("swap_same_d0", 32'(last_d0), 32'h3333);
        chk("swap_same_d1", 32'(last_d1), 32'h3333);

        // req1 raises valid only during ISSUE and withdraws: never granted
        r0 = n_rsp;
        set_req(0, 1'b1, OP_READ, 3'd6, 3'd1, 16'h0, 2'd0, 4'd0);
        @(posedge clk);
        #1 req0_valid = 0;
        set_req(1, 1'b1, OP_WRITE, 3'd4, 3'd0, 16'hDEAD, 2'd0, 4'd0);
        @(posedge clk);
        #1 req1_valid = 0;
        settle();
        chk("withdraw_rsp_count", 32'(n_rsp - r0), 32'd1);
        chk("withdraw_rsp_id", 32'(last_id), 32'h0);
        chk("withdraw_d0", 32'(last_d0), 32'hBBBB);

`ifdef RF_ARB_LOCK_EN
        // req1 locks while req0 stays valid: req1 served twice, then req0
        rsp_ids.delete();
        set_req(0, 1'b1, OP_READ, 3'd1, 3'd1, 16'h0, 2'd0, 4'd0);
        set_req(1, 1'b1, OP_READ, 3'd6, 3'd6, 16'h0, 2'd0, 4'd0);
        req1_lock = 1;
        @(posedge clk);
        #1 req1_lock = 0;
        repeat (2) @(posedge clk);
        #1 req1_valid = 0;
        repeat (2) @(posedge clk);
        #1 req0_valid = 0;
        settle();
        chk("lock_count", 32'(rsp_ids.size()), 32'd3);
        if (rsp_ids.size() == 3) begin
            chk("lock_g0", 32'(rsp_ids[0]), 32'h1);
            chk("lock_g1", 32'(rsp_ids[1]), 32'h1);
            chk("lock_g2", 32'(rsp_ids[2]), 32'h0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
